// File: rtl/interrupt_sequencer.sv
// Interrupt entry sequencer: detects an interrupt edge, drains the pipeline, pushes
// the resume PC (high word, low word) and CCR through the stack port, then vectors and acks.
module interrupt_sequencer #(
  parameter logic [31:0] VECTOR_ADDR  = 32'h0000_0000,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        interrupt,
  input  logic        pipe_busy,
  input  logic [31:0] resume_pc,
  input  logic [2:0]  ccr,
  input  logic        stack_gnt,
  output logic        stack_req,
  output logic        stack_push,
  output logic [15:0] stack_wr_data,
  output logic        freeze,
  output logic        flush_fetch,
  output logic        pc_load,
  output logic [31:0] pc_load_val,
  output logic        ccr_clear,
  output logic        ack,
  output logic        busy
);

  localparam int CW = $clog2(DRAIN_CYCLES) + 1;
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX    = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DRAIN    = 3'd1,
    S_PUSH_HI  = 3'd2,
    S_PUSH_LO  = 3'd3,
    S_PUSH_CCR = 3'd4,
    S_VECTOR   = 3'd5,
    S_ACK      = 3'd6
  } state_t;

  state_t          state_q, state_d;
  logic            int_q;
  logic            pending_q, pending_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     pc_q, pc_d;
  logic [2:0]      ccr_q, ccr_d;
  logic            rise;

  assign rise = interrupt & ~int_q;

  // State and capture registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      int_q     <= 1'b0;
      pending_q <= 1'b0;
      cnt_q     <= '0;
      pc_q      <= 32'h0000_0000;
      ccr_q     <= 3'b000;
    end else begin
      state_q   <= state_d;
      int_q     <= interrupt;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      pc_q      <= pc_d;
      ccr_q     <= ccr_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pc_d          = pc_q;
    ccr_d         = ccr_q;
    // pending holds the one request waiting behind the current service; it is consumed
    // when the service starts, and a rise in that same cycle re-arms it (set wins)
    pending_d     = pending_q | rise;
    stack_req     = 1'b0;
    stack_wr_data = 16'h0000;
    freeze        = 1'b0;
    flush_fetch   = 1'b0;
    pc_load       = 1'b0;
    pc_load_val   = 32'h0000_0000;
    ccr_clear     = 1'b0;
    ack           = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (pending_q) begin
          state_d   = S_DRAIN;
          pending_d = rise;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        freeze      = 1'b1;
        flush_fetch = (cnt_q == '0);
        if ((cnt_q >= DRAIN_LAST) && !pipe_busy) begin
          state_d = S_PUSH_HI;
          pc_d    = resume_pc;
          ccr_d   = ccr;
          cnt_d   = '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_PUSH_HI: begin
        freeze        = 1'b1;
        stack_req     = 1'b1;
        stack_wr_data = pc_q[31:16];
        state_d       = stack_gnt ? S_PUSH_LO : S_PUSH_HI;
      end
      S_PUSH_LO: begin
        freeze        = 1'b1;
        stack_req     = 1'b1;
        stack_wr_data = pc_q[15:0];
        state_d       = stack_gnt ? S_PUSH_CCR : S_PUSH_LO;
      end
      S_PUSH_CCR: begin
        freeze        = 1'b1;
        stack_req     = 1'b1;
        stack_wr_data = {13'b0, ccr_q};
        state_d       = stack_gnt ? S_VECTOR : S_PUSH_CCR;
      end
      S_VECTOR: begin
        freeze      = 1'b1;
        pc_load     = 1'b1;
        pc_load_val = VECTOR_ADDR;
        ccr_clear   = 1'b1;
        state_d     = S_ACK;
      end
      S_ACK: begin
        ack     = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign stack_push = stack_req & stack_gnt;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Self-checking bench for interrupt_sequencer: directed latency scenarios plus randomized
// traffic compared every cycle against a service-level reference model.
module tb_interrupt_sequencer;
  localparam logic [31:0] VEC = 32'hFFFF_8000;
  localparam int D = 3;

  logic        clk = 1'b0;
  logic        rst, interrupt, pipe_busy, stack_gnt;
  logic [31:0] resume_pc;
  logic [2:0]  ccr;
  logic        stack_req, stack_push, freeze, flush_fetch, pc_load, ccr_clear, ack, busy;
  logic [15:0] stack_wr_data;
  logic [31:0] pc_load_val;

  always #5 clk = ~clk;

  interrupt_sequencer #(.VECTOR_ADDR(VEC), .DRAIN_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .interrupt(interrupt), .pipe_busy(pipe_busy),
    .resume_pc(resume_pc), .ccr(ccr), .stack_gnt(stack_gnt),
    .stack_req(stack_req), .stack_push(stack_push), .stack_wr_data(stack_wr_data),
    .freeze(freeze), .flush_fetch(flush_fetch), .pc_load(pc_load),
    .pc_load_val(pc_load_val), .ccr_clear(ccr_clear), .ack(ack), .busy(busy)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // Reference model: one service = drain phase, three pushes, vector, ack
  bit          m_int_prev = 1'b0, m_pend = 1'b0, m_svc = 1'b0, m_drain = 1'b0;
  bit          m_vec = 1'b0, m_ack = 1'b0;
  int          m_dcnt = 0, m_pushes = 0;
  logic [15:0] m_words [3];

  int          push_cyc[$], load_cyc[$], ack_cyc[$], req_cyc[$], flush_cyc[$];
  logic [15:0] push_dat[$];
  bit          busy_log[$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_update();
    bit rise;
    if (rst) begin
      m_int_prev = 1'b0; m_pend = 1'b0; m_svc = 1'b0; m_drain = 1'b0;
      m_vec = 1'b0; m_ack = 1'b0; m_dcnt = 0; m_pushes = 0;
    end else begin
      rise = interrupt && !m_int_prev;
      m_int_prev = interrupt;
      if (!m_svc) begin
        if (m_pend) begin
          m_svc = 1'b1; m_drain = 1'b1; m_dcnt = 0; m_pushes = 0;
        end
        m_pend = rise ? 1'b1 : (m_pend && !m_svc);
      end else begin
        m_pend = m_pend || rise;
        if (m_drain) begin
          if (m_dcnt >= D - 1 && !pipe_busy) begin
            m_drain = 1'b0;
            m_words[0] = resume_pc[31:16];
            m_words[1] = resume_pc[15:0];
            m_words[2] = {13'b0, ccr};
          end else begin
            m_dcnt = m_dcnt + 1;
          end
        end else if (m_pushes < 3) begin
          if (stack_gnt) begin
            m_pushes = m_pushes + 1;
            if (m_pushes == 3) m_vec = 1'b1;
          end
        end else if (m_vec) begin
          m_vec = 1'b0; m_ack = 1'b1;
        end else begin
          m_ack = 1'b0; m_svc = 1'b0;
        end
      end
    end
  endtask

  task automatic step();
    logic        exp_req;
    logic [15:0] exp_dat;
    @(negedge clk);
    exp_req = m_svc && !m_drain && (m_pushes < 3);
    exp_dat = exp_req ? m_words[m_pushes] : 16'h0000;
    chk("busy",        {31'b0, busy},        {31'b0, m_svc});
    chk("freeze",      {31'b0, freeze},      {31'b0, m_svc && !m_ack});
    chk("flush_fetch", {31'b0, flush_fetch}, {31'b0, m_drain && (m_dcnt == 0)});
    chk("stack_req",   {31'b0, stack_req},   {31'b0, exp_req});
    chk("stack_push",  {31'b0, stack_push},  {31'b0, exp_req && stack_gnt});
    chk("stack_wr_data", {16'b0, stack_wr_data}, {16'b0, exp_dat});
    chk("pc_load",     {31'b0, pc_load},     {31'b0, m_vec});
    chk("pc_load_val", pc_load_val,          m_vec ? VEC : 32'h0000_0000);
    chk("ccr_clear",   {31'b0, ccr_clear},   {31'b0, m_vec});
    chk("ack",         {31'b0, ack},         {31'b0, m_ack});
    if (stack_push === 1'b1) begin push_cyc.push_back(cyc); push_dat.push_back(stack_wr_data); end
    if (pc_load === 1'b1) load_cyc.push_back(cyc);
    if (ack === 1'b1) ack_cyc.push_back(cyc);
    if (stack_req === 1'b1) req_cyc.push_back(cyc);
    if (flush_fetch === 1'b1) flush_cyc.push_back(cyc);
    busy_log.push_back(busy === 1'b1);
    @(posedge clk);
    model_update();
    cyc = cyc + 1;
    #1;
  endtask

  task automatic clr_logs();
    push_cyc.delete(); push_dat.delete(); load_cyc.delete();
    ack_cyc.delete(); req_cyc.delete(); flush_cyc.delete();
  endtask

  function automatic int at(int q[$], int i, int base);
    return (i < q.size()) ? q[i] - base : -1;
  endfunction

  int t0;
  int t1;

  initial begin
    rst = 1'b1; interrupt = 1'b0; pipe_busy = 1'b0; stack_gnt = 1'b1;
    resume_pc = 32'h0000_0000; ccr = 3'b000;
    @(posedge clk);
    #1;
    step(); step();
    chk("reset_busy", {31'b0, busy}, 32'd0);
    rst = 1'b0;
    step(); step();

    // T1 basic latency
    resume_pc = 32'h0001_0234; ccr = 3'b101;
    clr_logs(); t0 = cyc;
    for (int k = 0; k < 13; k++) begin
      interrupt = (k == 0);
      step();
    end
    chk("t1_npush", push_cyc.size(), 32'd3);
    chk("t1_push0_cyc", at(push_cyc, 0, t0), 32'd5);
    chk("t1_push1_cyc", at(push_cyc, 1, t0), 32'd6);
    chk("t1_push2_cyc", at(push_cyc, 2, t0), 32'd7);
    chk("t1_push0_dat", (push_dat.size() > 0) ? {16'b0, push_dat[0]} : 32'hFFFF_FFFF, 32'h0000_0001);
    chk("t1_push1_dat", (push_dat.size() > 1) ? {16'b0, push_dat[1]} : 32'hFFFF_FFFF, 32'h0000_0234);
    chk("t1_push2_dat", (push_dat.size() > 2) ? {16'b0, push_dat[2]} : 32'hFFFF_FFFF, 32'h0000_0005);
    chk("t1_load_cyc", at(load_cyc, 0, t0), 32'd8);
    chk("t1_ack_cyc", at(ack_cyc, 0, t0), 32'd9);
    chk("t1_busy9", {31'b0, busy_log[t0 + 9]}, 32'd1);
    chk("t1_busy10", {31'b0, busy_log[t0 + 10]}, 32'd0);

    // T2 grant stall in PUSH_LO
    clr_logs(); t0 = cyc;
    for (int k = 0; k < 16; k++) begin
      interrupt = (k == 0);
      stack_gnt = !(k >= 6 && k <= 9);
      step();
    end
    stack_gnt = 1'b1;
    chk("t2_npush", push_cyc.size(), 32'd3);
    chk("t2_lo_cyc", at(push_cyc, 1, t0), 32'd10);
    chk("t2_lo_dat", (push_dat.size() > 1) ? {16'b0, push_dat[1]} : 32'hFFFF_FFFF, 32'h0000_0234);
    chk("t2_ack_cyc", at(ack_cyc, 0, t0), 32'd13);

    // T3 drain blocked by pipe_busy
    clr_logs(); t0 = cyc;
    for (int k = 0; k < 15; k++) begin
      interrupt = (k == 0);
      pipe_busy = (k >= 2 && k <= 7);
      step();
    end
    pipe_busy = 1'b0;
    chk("t3_first_req", at(req_cyc, 0, t0), 32'd9);
    chk("t3_nflush", flush_cyc.size(), 32'd1);
    chk("t3_flush_cyc", at(flush_cyc, 0, t0), 32'd2);
    chk("t3_ack_cyc", at(ack_cyc, 0, t0), 32'd13);

    // T4 queueing: second rise queued, third dropped
    clr_logs(); t0 = cyc;
    for (int k = 0; k < 30; k++) begin
      interrupt = (k == 0 || k == 5 || k == 7);
      step();
    end
    chk("t4_nack", ack_cyc.size(), 32'd2);
    chk("t4_ack1_cyc", at(ack_cyc, 1, t0), 32'd18);
    chk("t4_npush", push_cyc.size(), 32'd6);

    // T5 level held high
    clr_logs(); t0 = cyc;
    for (int k = 0; k < 60; k++) begin
      interrupt = (k < 50);
      step();
    end
    chk("t5_nack", ack_cyc.size(), 32'd1);
    chk("t5_npush", push_cyc.size(), 32'd3);
    chk("t5_ack_cyc", at(ack_cyc, 0, t0), 32'd9);

    // T6 reset during PUSH_LO, then a normal service
    resume_pc = 32'hCAFE_1357; ccr = 3'b011;
    clr_logs(); t0 = cyc;
    for (int k = 0; k < 15; k++) begin
      interrupt = (k == 0);
      rst = (k == 6);
      stack_gnt = (k != 6);
      step();
    end
    rst = 1'b0; stack_gnt = 1'b1;
    chk("t6_busy_after_rst", {31'b0, busy_log[t0 + 7]}, 32'd0);
    chk("t6_npush", push_cyc.size(), 32'd1);
    chk("t6_nack", ack_cyc.size(), 32'd0);
    clr_logs(); t1 = cyc;
    for (int k = 0; k < 13; k++) begin
      interrupt = (k == 0);
      step();
    end
    chk("t6_resvc_ack", at(ack_cyc, 0, t1), 32'd9);
    chk("t6_resvc_npush", push_cyc.size(), 32'd3);
    chk("t6_resvc_hi", (push_dat.size() > 0) ? {16'b0, push_dat[0]} : 32'hFFFF_FFFF, 32'h0000_CAFE);

    // Randomized traffic against the model
    clr_logs();
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 5) == 0) interrupt = ~interrupt;
      pipe_busy = ($urandom_range(0, 3) == 0);
      stack_gnt = ($urandom_range(0, 9) < 7);
      resume_pc = $urandom;
      ccr = 3'($urandom_range(0, 7));
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;
    chk("rand_acks_seen", {31'b0, ack_cyc.size() > 0}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
